// File: rtl/pwm_capture_if.sv
// PWM capture port bundle: the raw PWM input plus the measurement results.
// The master side drives the waveform and reads results; the slave side is
// the capture block itself.
interface pwm_capture_if #(
  parameter int CNT_W = 20
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_count;
  logic [CNT_W-1:0] period_count;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  modport master (
    output pwm_in,
    input  high_count,
    input  period_count,
    input  meas_valid,
    input  stuck,
    input  stuck_level
  );

  modport slave (
    input  pwm_in,
    output high_count,
    output period_count,
    output meas_valid,
    output stuck,
    output stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures the high time and rise-to-rise period of an
// asynchronous PWM input in clk cycles, and flags a lost or constant input
// when no rising edge arrives within TIMEOUT cycles.
//
// The first rising edge after reset or after a timeout only arms the block;
// a measurement is reported on every later rising edge. When a rising edge
// and the timeout coincide the edge wins, so a period of exactly TIMEOUT is
// still measured. Results hold across a timeout; only stuck reports loss.
module pwm_capture #(
  parameter int               CNT_W   = 20,
  parameter logic [CNT_W-1:0] TIMEOUT = 20'd20_000
) (
  input  logic           clk,
  input  logic           rst_n,
  pwm_capture_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Input conditioning: two synchronizer stages then one delay stage.
  logic sync1;
  logic pwm_s;
  logic pwm_d;
  logic rise;
  logic fall;

  // Measurement state.
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_lat;
  logic             timeout_hit;
  state_t           state;
  state_t           state_next;

  // Decoded actions from the FSM output process.
  logic meas_fire;
  logic hi_load;
  logic stuck_set;
  logic stuck_clr;
  logic track_level;

  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;

  // A rising edge always takes priority over the timeout.
  assign timeout_hit = (cnt == TIMEOUT) & ~rise;

  // Synchronize the asynchronous input and keep a delayed copy for edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      sync1 <= bus.pwm_in;
      pwm_s <= sync1;
      pwm_d <= pwm_s;
    end
  end

  // Cycle counter: restarts at 1 on every rise, otherwise saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= CNT_ZERO;
    end else if (rise) begin
      cnt <= CNT_ONE;
    end else if (cnt == TIMEOUT) begin
      cnt <= cnt;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: rise re-enters S_HIGH, timeout drops to S_IDLE, fall ends the high phase.
  always_comb begin
    state_next = state;
    if (rise) begin
      state_next = S_HIGH;
    end else if (timeout_hit) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_next = S_IDLE;
        end
        S_HIGH: begin
          if (fall) begin
            state_next = S_LOW;
          end else begin
            state_next = S_HIGH;
          end
        end
        S_LOW: begin
          state_next = S_LOW;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // FSM outputs: decode which registers update this cycle.
  always_comb begin
    meas_fire   = 1'b0;
    hi_load     = 1'b0;
    stuck_set   = timeout_hit;
    stuck_clr   = rise;
    track_level = 1'b0;
    case (state)
      S_IDLE: begin
        meas_fire = 1'b0;
        hi_load   = 1'b0;
      end
      S_HIGH: begin
        meas_fire = 1'b0;
        hi_load   = fall & ~timeout_hit;
      end
      S_LOW: begin
        meas_fire = rise;
        hi_load   = 1'b0;
      end
      default: begin
        meas_fire = 1'b0;
        hi_load   = 1'b0;
      end
    endcase
    if (!rise && (timeout_hit || bus.stuck)) begin
      track_level = 1'b1;
    end else begin
      track_level = 1'b0;
    end
  end

  // Latch the high time at the falling edge of the current period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_lat <= CNT_ZERO;
    end else if (hi_load) begin
      hi_lat <= cnt;
    end else begin
      hi_lat <= hi_lat;
    end
  end

  // Registered measurement results and the valid strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.high_count   <= CNT_ZERO;
      bus.period_count <= CNT_ZERO;
      bus.meas_valid   <= 1'b0;
    end else begin
      bus.meas_valid <= meas_fire;
      if (meas_fire) begin
        bus.high_count   <= hi_lat;
        bus.period_count <= cnt;
      end else begin
        bus.high_count   <= bus.high_count;
        bus.period_count <= bus.period_count;
      end
    end
  end

  // Loss-of-signal flag and the input level seen while it is raised.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.stuck       <= 1'b0;
      bus.stuck_level <= 1'b0;
    end else begin
      if (stuck_clr) begin
        bus.stuck <= 1'b0;
      end else if (stuck_set) begin
        bus.stuck <= 1'b1;
      end else begin
        bus.stuck <= bus.stuck;
      end
      if (track_level) begin
        bus.stuck_level <= pwm_s;
      end else begin
        bus.stuck_level <= bus.stuck_level;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture with TIMEOUT = 100. Expected measurements are
// queued just before the rising edge that completes a period and are popped
// by a monitor whenever meas_valid is seen.
module tb_pwm_capture;
  localparam int               CNT_W = 20;
  localparam logic [CNT_W-1:0] TMO   = 20'd100;

  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] p;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   checks     = 0;
  int   passed     = 0;
  int   meas_seen  = 0;
  logic prev_mv    = 1'b0;
  logic stuck_seen = 1'b0;

  always #5 clk = ~clk;

  // Scoreboard monitor: compare every meas_valid against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.meas_valid === 1'b1) begin
      meas_seen++;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: meas_valid with nothing queued, got high=%0d period=%0d",
                 bus.high_count, bus.period_count);
      end else begin
        mon_e = sb.pop_front();
        if (bus.high_count !== mon_e.h || bus.period_count !== mon_e.p)
          $display("FAIL sb_meas: got high=%0d period=%0d, expected high=%0d period=%0d",
                   bus.high_count, bus.period_count, mon_e.h, mon_e.p);
        else passed++;
      end
      checks++;
      if (prev_mv === 1'b1) $display("FAIL meas_pulse_width: meas_valid high two cycles in a row, expected one");
      else passed++;
    end
    if (bus.stuck === 1'b1) stuck_seen = 1'b1;
    prev_mv = bus.meas_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_period(input int h, input int p);
    bus.pwm_in = 1'b1;
    tick(h);
    bus.pwm_in = 1'b0;
    tick(p - h);
  endtask

  task automatic push(input int h, input int p);
    exp_t e;
    e.h = CNT_W'(h);
    e.p = CNT_W'(p);
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    bus.pwm_in = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.high_count !== 20'd0) $display("FAIL rst_high: got %0d expected 0", bus.high_count); else passed++;
    checks++; if (bus.period_count !== 20'd0) $display("FAIL rst_period: got %0d expected 0", bus.period_count); else passed++;
    checks++; if (bus.meas_valid !== 1'b0) $display("FAIL rst_valid: got %0b expected 0", bus.meas_valid); else passed++;
    checks++; if (bus.stuck !== 1'b0) $display("FAIL rst_stuck: got %0b expected 0", bus.stuck); else passed++;
    checks++; if (bus.stuck_level !== 1'b0) $display("FAIL rst_level: got %0b expected 0", bus.stuck_level); else passed++;
  endtask

  task automatic test_steady();
    int base;
    apply_reset();
    base = meas_seen;
    drive_period(3, 10);
    checks++; if (meas_seen != base) $display("FAIL steady_arm: got %0d strobes expected 0", meas_seen - base); else passed++;
    push(3, 10);
    bus.pwm_in = 1'b1;
    tick(2);
    checks++; if (bus.meas_valid !== 1'b0) $display("FAIL steady_latency_early: got %0b expected 0", bus.meas_valid); else passed++;
    tick(1);
    checks++; if (bus.meas_valid !== 1'b1) $display("FAIL steady_latency: got %0b expected 1", bus.meas_valid); else passed++;
    bus.pwm_in = 1'b0;
    tick(7);
    repeat (4) begin
      push(3, 10);
      drive_period(3, 10);
    end
    tick(5);
    checks++; if (meas_seen - base != 5) $display("FAIL steady_count: got %0d expected 5", meas_seen - base); else passed++;
    checks++; if (bus.high_count !== 20'd3) $display("FAIL steady_high: got %0d expected 3", bus.high_count); else passed++;
    checks++; if (bus.period_count !== 20'd10) $display("FAIL steady_period: got %0d expected 10", bus.period_count); else passed++;
    checks++; if (bus.stuck !== 1'b0) $display("FAIL steady_stuck: got %0b expected 0", bus.stuck); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL steady_drain: %0d expected entries left, expected 0", sb.size()); else passed++;
  endtask

  task automatic test_stuck_low();
    int base;
    apply_reset();
    base = meas_seen;
    tick(int'(TMO));
    checks++; if (bus.stuck !== 1'b0) $display("FAIL stuck_low_early: got %0b expected 0", bus.stuck); else passed++;
    tick(1);
    checks++; if (bus.stuck !== 1'b1) $display("FAIL stuck_low_set: got %0b expected 1", bus.stuck); else passed++;
    tick(10);
    checks++; if (bus.stuck_level !== 1'b0) $display("FAIL stuck_low_level: got %0b expected 0", bus.stuck_level); else passed++;
    checks++; if (meas_seen != base) $display("FAIL stuck_low_nomeas: got %0d strobes expected 0", meas_seen - base); else passed++;
    bus.pwm_in = 1'b1;
    tick(2);
    checks++; if (bus.stuck !== 1'b1) $display("FAIL stuck_clear_early: got %0b expected 1", bus.stuck); else passed++;
    tick(1);
    checks++; if (bus.stuck !== 1'b0) $display("FAIL stuck_clear: got %0b expected 0", bus.stuck); else passed++;
    tick(2);
    bus.pwm_in = 1'b0;
    tick(15);
    push(5, 20);
    drive_period(5, 20);
    tick(5);
    checks++; if (meas_seen - base != 1) $display("FAIL recover_count: got %0d expected 1", meas_seen - base); else passed++;
    checks++; if (bus.high_count !== 20'd5) $display("FAIL recover_high: got %0d expected 5", bus.high_count); else passed++;
    checks++; if (bus.period_count !== 20'd20) $display("FAIL recover_period: got %0d expected 20", bus.period_count); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL recover_drain: %0d expected entries left, expected 0", sb.size()); else passed++;
  endtask

  task automatic test_stuck_high();
    int base;
    apply_reset();
    base = meas_seen;
    drive_period(4, 10);
    push(4, 10);
    drive_period(4, 10);
    push(4, 10);
    bus.pwm_in = 1'b1;
    tick(int'(TMO) + 10);
    checks++; if (bus.stuck !== 1'b1) $display("FAIL stuck_high_set: got %0b expected 1", bus.stuck); else passed++;
    checks++; if (bus.stuck_level !== 1'b1) $display("FAIL stuck_high_level: got %0b expected 1", bus.stuck_level); else passed++;
    checks++; if (bus.high_count !== 20'd4) $display("FAIL stuck_high_hold_high: got %0d expected 4", bus.high_count); else passed++;
    checks++; if (bus.period_count !== 20'd10) $display("FAIL stuck_high_hold_period: got %0d expected 10", bus.period_count); else passed++;
    checks++; if (meas_seen - base != 2) $display("FAIL stuck_high_count: got %0d expected 2", meas_seen - base); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL stuck_high_drain: %0d expected entries left, expected 0", sb.size()); else passed++;
  endtask

  task automatic test_timeout_boundary();
    int base;
    apply_reset();
    stuck_seen = 1'b0;
    base = meas_seen;
    drive_period(2, 100);
    push(2, 100);
    drive_period(2, 101);
    checks++; if (stuck_seen !== 1'b0) $display("FAIL bound_100_nostuck: stuck seen %0b expected 0", stuck_seen); else passed++;
    checks++; if (meas_seen - base != 1) $display("FAIL bound_100_count: got %0d expected 1", meas_seen - base); else passed++;
    checks++; if (bus.period_count !== 20'd100) $display("FAIL bound_100_period: got %0d expected 100", bus.period_count); else passed++;
    bus.pwm_in = 1'b1;
    tick(2);
    checks++; if (bus.stuck !== 1'b1) $display("FAIL bound_101_stuck: got %0b expected 1", bus.stuck); else passed++;
    tick(3);
    bus.pwm_in = 1'b0;
    tick(5);
    checks++; if (meas_seen - base != 1) $display("FAIL bound_101_nomeas: got %0d expected 1", meas_seen - base); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL bound_drain: %0d expected entries left, expected 0", sb.size()); else passed++;
  endtask

  task automatic test_min_period();
    int base;
    apply_reset();
    base = meas_seen;
    drive_period(1, 2);
    repeat (6) begin
      push(1, 2);
      drive_period(1, 2);
    end
    tick(5);
    checks++; if (meas_seen - base != 6) $display("FAIL min_count: got %0d expected 6", meas_seen - base); else passed++;
    checks++; if (bus.high_count !== 20'd1) $display("FAIL min_high: got %0d expected 1", bus.high_count); else passed++;
    checks++; if (bus.period_count !== 20'd2) $display("FAIL min_period: got %0d expected 2", bus.period_count); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL min_drain: %0d expected entries left, expected 0", sb.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    int base;
    apply_reset();
    base = meas_seen;
    drive_period(3, 10);
    push(3, 10);
    bus.pwm_in = 1'b1;
    tick(3);
    bus.pwm_in = 1'b0;
    tick(3);
    checks++; if (meas_seen - base != 1) $display("FAIL mid_pre_count: got %0d expected 1", meas_seen - base); else passed++;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    checks++; if (bus.high_count !== 20'd0) $display("FAIL mid_rst_high: got %0d expected 0", bus.high_count); else passed++;
    checks++; if (bus.period_count !== 20'd0) $display("FAIL mid_rst_period: got %0d expected 0", bus.period_count); else passed++;
    checks++; if (bus.meas_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0b expected 0", bus.meas_valid); else passed++;
    checks++; if (bus.stuck !== 1'b0) $display("FAIL mid_rst_stuck: got %0b expected 0", bus.stuck); else passed++;
    tick(4);
    base = meas_seen;
    drive_period(3, 10);
    checks++; if (meas_seen != base) $display("FAIL mid_rearm: got %0d strobes expected 0", meas_seen - base); else passed++;
    push(3, 10);
    drive_period(3, 10);
    tick(5);
    checks++; if (meas_seen - base != 1) $display("FAIL mid_post_count: got %0d expected 1", meas_seen - base); else passed++;
    checks++; if (bus.high_count !== 20'd3) $display("FAIL mid_post_high: got %0d expected 3", bus.high_count); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL mid_drain: %0d expected entries left, expected 0", sb.size()); else passed++;
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    test_reset();
    test_steady();
    test_stuck_low();
    test_stuck_high();
    test_timeout_boundary();
    test_min_period();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
